// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_pkg : receive-controller state encoding and frame bit indices |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic [3:0] START_IDX  = 4'd0;
  localparam logic [3:0] DATA_FIRST = 4'd1;
  localparam logic [3:0] DATA_LAST  = 4'd8;
  localparam logic [3:0] PARITY_IDX = 4'd9;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_ctrl_if : serial line, config and status bundle of the RX ctrl|
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_WIDTH = 5
);

  logic                      RX_IN;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      sampled_bit;
  logic                      dat_samp_en;
  logic [PRESCALE_WIDTH-1:0] edge_count;
  logic [3:0]                bit_count;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;
  logic                      busy;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, prescale, sampled_bit,
    input  dat_samp_en, edge_count, bit_count, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, prescale, sampled_bit,
    output dat_samp_en, edge_count, bit_count, data_valid, par_err, stp_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_bit_counter : oversample index and frame bit index counters      |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module edge_bit_counter #(
  parameter int PRESCALE_WIDTH = 5
) (
  input  wire                       CLK,
  input  wire                       RST,
  input  wire                       i_en,
  input  wire                       i_clr,
  input  wire [PRESCALE_WIDTH-1:0]  i_prescale,
  output logic [PRESCALE_WIDTH-1:0] o_edge_count,
  output logic [3:0]                o_bit_count,
  output logic                      o_bit_end
);

  localparam logic [PRESCALE_WIDTH-1:0] C_ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] r_edge;
  logic [3:0]                r_bit;

  assign o_bit_end    = i_en && (r_edge == (i_prescale - C_ONE));
  assign o_edge_count = r_edge;
  assign o_bit_count  = r_bit;

  // Clear wins so the counters already read 0 in the first idle cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (i_clr) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (i_en) begin
      if (o_bit_end) begin
        r_edge <= '0;
        r_bit  <= r_bit + 4'd1;
      end else begin
        r_edge <= r_edge + C_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_ctrl : UART receive frame controller; parity via UART_RX_PARITY_EN |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5
) (
  input wire            CLK,
  input wire            RST,
  uart_rx_ctrl_if.slave bus
);

  rx_state_t                 r_state;
  rx_state_t                 w_next_state;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] w_edge_count;
  logic [3:0]                w_bit_count;
  logic                      w_bit_end;
  logic                      w_cnt_en;
  logic                      w_cnt_clr;
  logic                      w_load_cfg;
  logic                      r_stp_err;
  logic                      w_stp_err_nxt;
  logic                      r_data_valid;
  logic                      w_data_valid_nxt;

`ifdef UART_RX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic r_xor_acc;
  logic w_xor_nxt;
  logic r_par_err;
  logic w_par_err_nxt;
`else
  logic w_unused_par;
  assign w_unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  assign w_cnt_en  = (r_state != ST_IDLE);
  assign w_cnt_clr = (w_next_state == ST_IDLE);

  edge_bit_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_counter (
    .CLK          (CLK),
    .RST          (RST),
    .i_en         (w_cnt_en),
    .i_clr        (w_cnt_clr),
    .i_prescale   (r_prescale),
    .o_edge_count (w_edge_count),
    .o_bit_count  (w_bit_count),
    .o_bit_end    (w_bit_end)
  );

  always_comb begin
    w_next_state     = r_state;
    w_load_cfg       = 1'b0;
    w_stp_err_nxt    = r_stp_err;
    w_data_valid_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_xor_nxt        = r_xor_acc;
    w_par_err_nxt    = r_par_err;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!bus.RX_IN) begin
          w_next_state  = ST_START;
          w_load_cfg    = 1'b1;
          w_stp_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
          w_xor_nxt     = 1'b0;
          w_par_err_nxt = 1'b0;
`endif
        end
      end
      ST_START: begin
        // A start bit that votes high was line noise: abandon quietly.
        if (w_bit_end && (w_bit_count == START_IDX)) begin
          w_next_state = bus.sampled_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (w_bit_count >= DATA_FIRST)) begin
`ifdef UART_RX_PARITY_EN
          w_xor_nxt = r_xor_acc ^ bus.sampled_bit;
          if (w_bit_count == DATA_LAST) begin
            w_next_state = r_par_en ? ST_PARITY : ST_STOP;
          end
`else
          if (w_bit_count == DATA_LAST) begin
            w_next_state = ST_STOP;
          end
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end && (w_bit_count == PARITY_IDX)) begin
          w_par_err_nxt = ((bus.sampled_bit ^ r_xor_acc) != r_par_typ);
          w_next_state  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_stp_err_nxt = ~bus.sampled_bit;
`ifdef UART_RX_PARITY_EN
          w_data_valid_nxt = bus.sampled_bit & ~r_par_err;
`else
          w_data_valid_nxt = bus.sampled_bit;
`endif
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_prescale   <= '0;
      r_stp_err    <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_stp_err    <= w_stp_err_nxt;
      r_data_valid <= w_data_valid_nxt;
      if (w_load_cfg) begin
        r_prescale <= bus.prescale;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_xor_acc <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_xor_acc <= w_xor_nxt;
      r_par_err <= w_par_err_nxt;
      if (w_load_cfg) begin
        r_par_en  <= bus.PAR_EN;
        r_par_typ <= bus.PAR_TYP;
      end
    end
  end
  assign bus.par_err = r_par_err;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.dat_samp_en = w_cnt_en;
  assign bus.busy        = w_cnt_en;
  assign bus.edge_count  = w_edge_count;
  assign bus.bit_count   = w_bit_count;
  assign bus.data_valid  = r_data_valid;
  assign bus.stp_err     = r_stp_err;

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter: PRESCALE_WIDTH, 5, width of prescale and edge_count.
REQ-002 SHALL have port: CLK  input  1  single clock for all logic.
REQ-003 SHALL have port: RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: RX_IN  input  1  serial line, idle high.
REQ-005 SHALL have port: PAR_EN  input  1  parity bit present in the frame.
REQ-006 SHALL have port: PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-007 SHALL have port: prescale  input  PRESCALE_WIDTH  oversampling clocks per bit; legal values 8 and 16.
REQ-008 SHALL have port: sampled_bit  input  1  majority-voted bit from the data sampler.
REQ-009 SHALL have port: dat_samp_en  output  1  sampler enable.
REQ-010 SHALL have port: edge_count  output  PRESCALE_WIDTH  oversample index within the current bit.
REQ-011 SHALL have port: bit_count  output  4  frame bit index: 0 = start, 1..8 = data, 9 = parity/stop, 10 = stop.
REQ-012 SHALL have port: data_valid  output  1  one-cycle pulse when a frame is good.
REQ-013 SHALL have port: par_err  output  1  parity mismatch in the last frame.
REQ-014 SHALL have port: stp_err  output  1  stop bit sampled 0 in the last frame.
REQ-015 SHALL have port: busy  output  1  a frame is in progress.

Function
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START when RX_IN == 0; edge_count = 0 and bit_count = 0 on entry.
REQ-018 edge_count SHALL increment each cycle outside IDLE and wrap to 0 at prescale-1.
REQ-019 bit_count SHALL increment on the wrap cycle.
REQ-020 The end-of-bit decision point is edge_count == prescale-1; sampled_bit is read only there.
REQ-021 START end: sampled_bit == 1 (glitch) -> IDLE with no flags changed; sampled_bit == 0 -> DATA.
REQ-022 DATA SHALL accumulate the XOR of sampled_bit over bits 1..8.
REQ-023 DATA end of bit 8 -> PARITY if PAR_EN, else STOP.
REQ-024 PARITY end SHALL set par_err = (sampled_bit ^ xor_acc) != PAR_TYP, then go to STOP.
REQ-025 STOP end SHALL set stp_err = ~sampled_bit, then go to IDLE.
REQ-026 STOP end SHALL pulse data_valid for exactly 1 cycle iff the frame's stp_err and par_err are both 0.
REQ-027 par_err and stp_err SHALL hold until the next frame's START entry, where both clear.
REQ-028 dat_samp_en and busy SHALL be 1 in all states except IDLE.
REQ-029 edge_count and bit_count SHALL be held at 0 in IDLE.
REQ-030 Back-to-back frames: if RX_IN == 0 in the first IDLE cycle, START SHALL be entered on the next edge, giving a re-sync lag of at most 1 cycle.
REQ-031 PAR_EN, PAR_TYP and prescale SHALL be sampled only on IDLE -> START and held for the frame.

Reset
REQ-032 RST low SHALL force the FSM to IDLE and all outputs, counters and xor_acc to 0, asynchronously, including mid-frame.
REQ-033 After RST release, the first frame SHALL be decoded correctly with no spurious data_valid.

Configuration
REQ-034 Macro UART_RX_PARITY_EN defined: PARITY state, PAR_EN, PAR_TYP and par_err are fully functional.
REQ-035 Macro UART_RX_PARITY_EN undefined: PARITY state and xor_acc are not built; PAR_EN and PAR_TYP are ignored; par_err is tied 0; frames are always 10 bits.

Structure
REQ-036 Package uart_rx_pkg SHALL hold the state encoding and the constants START_IDX = 0, DATA_FIRST = 1, DATA_LAST = 8, PARITY_IDX = 9.
REQ-037 Sub-module edge_bit_counter SHALL own edge_count and bit_count, with enable and wrap-on-prescale inputs.

Verification
REQ-038 prescale = 8, no parity, frame 0xA5 -> data_valid pulses 80 (+/-1) cycles after RX_IN falls; par_err = 0, stp_err = 0.
REQ-039 prescale = 16, PAR_EN = 1, PAR_TYP = 0, frame 0x0F with parity 0 -> data_valid pulses once; par_err = 0.
REQ-040 Same as REQ-039 with parity bit 1 -> no data_valid; par_err = 1 until the next start.
REQ-041 prescale = 8, RX_IN low for 2 cycles only -> return to IDLE; busy drops after 8 cycles; no flags set.
REQ-042 prescale = 8, stop bit driven 0 -> stp_err = 1; no data_valid.
REQ-043 RST asserted at bit_count = 4, then a clean frame 0x3C -> all outputs 0 during reset; exactly one data_valid for the new frame.
